// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Readback monitor for a multiplexed 4-digit 7-segment display bus.
//   The scanned seg/dig_sel pins are sampled each cycle. Once a selected
//   digit has held steady for SETTLE_CYCLES samples, its glyph is decoded
//   into a slot. When all four slots are filled, the frame is published and
//   MM:SS is rebuilt. o_stale flags a bus that has produced no frame for
//   TIMEOUT_CYCLES cycles.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-low reset
//   seg[7:0]       active-low segments {dp,g,f,e,d,c,b,a}
//   dig_sel[3:0]   active-low one-hot anode select, bit0 = dig1 (rightmost)
//   o_dig1..4      decoded digit values of the last complete frame
//   o_blank        per-digit flag: all segments off
//   o_bad          per-digit flag: not a legal 0-9 glyph and not blank
//   o_dp           per-digit flag: decimal point lit
//   o_seconds      dig2*10+dig1 when o_time_ok, else 0
//   o_minutes      dig4*10+dig3 when o_time_ok, else 0
//   o_time_ok      all digits legal and both tens digits <= 5
//   o_frame_valid  one-cycle pulse when the frame outputs update
//   o_stale        no frame completed within TIMEOUT_CYCLES
module sevenseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] seg,
  input  logic [3:0] dig_sel,
  output logic [3:0] o_dig1,
  output logic [3:0] o_dig2,
  output logic [3:0] o_dig3,
  output logic [3:0] o_dig4,
  output logic [3:0] o_blank,
  output logic [3:0] o_bad,
  output logic [3:0] o_dp,
  output logic [5:0] o_seconds,
  output logic [5:0] o_minutes,
  output logic       o_time_ok,
  output logic       o_frame_valid,
  output logic       o_stale
);

  localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [23:0] TMO_MAX    = 24'(TIMEOUT_CYCLES);

  function automatic logic one_hot_low(input logic [3:0] d);
    case (d)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] slot_index(input logic [3:0] d);
    case (d)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Returns {value[3:0], blank, bad}
  function automatic logic [5:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h40:   return {4'd0, 2'b00};
      7'h79:   return {4'd1, 2'b00};
      7'h24:   return {4'd2, 2'b00};
      7'h30:   return {4'd3, 2'b00};
      7'h19:   return {4'd4, 2'b00};
      7'h12:   return {4'd5, 2'b00};
      7'h02:   return {4'd6, 2'b00};
      7'h78:   return {4'd7, 2'b00};
      7'h00:   return {4'd8, 2'b00};
      7'h10:   return {4'd9, 2'b00};
      7'h7F:   return {4'd0, 2'b10};
      default: return {4'hF, 2'b01};
    endcase
  endfunction

  function automatic logic [5:0] tens_ones(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] sum;
    sum = 7'(tens) * 7'd10 + 7'(ones);
    return sum[5:0];
  endfunction

  // ---- Stage p0/p1: pin sample S and previous sample ----
  logic [7:0] seg_p0, seg_p1;
  logic [3:0] dig_sel_p0, dig_sel_p1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dig_sel_p0 <= 4'hF;
      dig_sel_p1 <= 4'hF;
    end else begin
      dig_sel_p0 <= dig_sel;
      dig_sel_p1 <= dig_sel_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    seg_p0 <= seg;
    seg_p1 <= seg_p0;
  end

  logic [7:0] settle_cnt, settle_nxt;
  logic       sel_ok, capture;
  logic [1:0] cap_k;
  logic [5:0] cap_dec;

  always_comb begin
    sel_ok     = one_hot_low(dig_sel_p0);
    settle_nxt = 8'd0;
    if (sel_ok && (seg_p0 == seg_p1) && (dig_sel_p0 == dig_sel_p1))
      settle_nxt = (settle_cnt >= SETTLE_MAX) ? SETTLE_MAX : settle_cnt + 8'd1;
    else if (sel_ok)
      settle_nxt = 8'd1;
    // Fires only on the transition into SETTLE_MAX, so a long dwell captures once.
    capture = (settle_nxt == SETTLE_MAX) && (settle_cnt != SETTLE_MAX);
    cap_k   = slot_index(dig_sel_p0);
    cap_dec = decode_glyph(seg_p0[6:0]);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) settle_cnt <= 8'd0;
    else        settle_cnt <= settle_nxt;
  end

  // ---- Stage p1: slot capture and frame assembly ----
  logic [3:0] slot_val [4];
  logic [3:0] slot_blank, slot_bad, slot_dp;
  logic [3:0] mask;
  logic       frame_pend;

  always_ff @(posedge i_clk) begin
    if (capture) begin
      slot_val[cap_k]   <= cap_dec[5:2];
      slot_blank[cap_k] <= cap_dec[1];
      slot_bad[cap_k]   <= cap_dec[0];
      slot_dp[cap_k]    <= ~seg_p0[7];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mask       <= 4'h0;
      frame_pend <= 1'b0;
    end else begin
      frame_pend <= 1'b0;
      if (frame_pend) begin
        mask <= 4'h0;
      end else if (capture) begin
        mask <= mask | ~dig_sel_p0;
        if ((mask | ~dig_sel_p0) == 4'hF) frame_pend <= 1'b1;
      end
    end
  end

  // ---- Stage p2: frame publish and staleness timeout ----
  logic        frame_ok;
  logic [23:0] tmo_cnt;

  always_comb begin
    frame_ok = (slot_blank == 4'h0) && (slot_bad == 4'h0) &&
               (slot_val[1] <= 4'd5) && (slot_val[3] <= 4'd5);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_dig1        <= 4'd0;
      o_dig2        <= 4'd0;
      o_dig3        <= 4'd0;
      o_dig4        <= 4'd0;
      o_blank       <= 4'd0;
      o_bad         <= 4'd0;
      o_dp          <= 4'd0;
      o_seconds     <= 6'd0;
      o_minutes     <= 6'd0;
      o_time_ok     <= 1'b0;
      o_frame_valid <= 1'b0;
      o_stale       <= 1'b1;
      tmo_cnt       <= 24'd0;
    end else begin
      o_frame_valid <= frame_pend;
      if (frame_pend) begin
        o_dig1    <= slot_val[0];
        o_dig2    <= slot_val[1];
        o_dig3    <= slot_val[2];
        o_dig4    <= slot_val[3];
        o_blank   <= slot_blank;
        o_bad     <= slot_bad;
        o_dp      <= slot_dp;
        o_time_ok <= frame_ok;
        o_seconds <= frame_ok ? tens_ones(slot_val[1], slot_val[0]) : 6'd0;
        o_minutes <= frame_ok ? tens_ones(slot_val[3], slot_val[2]) : 6'd0;
        tmo_cnt   <= 24'd0;
        o_stale   <= 1'b0;
      end else begin
        if (tmo_cnt < TMO_MAX) tmo_cnt <= tmo_cnt + 24'd1;
        if (tmo_cnt + 24'd1 >= TMO_MAX) o_stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scan scenarios plus a randomized
// dwell sequence, checked against a dwell-level reference model.
module tb_sevenseg_scan_decoder;
  localparam int SETTLE = 16;
  localparam int TMO    = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] seg = 8'hFF;
  logic [3:0] dig_sel = 4'hF;
  logic [3:0] o_dig1, o_dig2, o_dig3, o_dig4, o_blank, o_bad, o_dp;
  logic [5:0] o_seconds, o_minutes;
  logic       o_time_ok, o_frame_valid, o_stale;

  sevenseg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst_n), .seg(seg), .dig_sel(dig_sel),
    .o_dig1(o_dig1), .o_dig2(o_dig2), .o_dig3(o_dig3), .o_dig4(o_dig4),
    .o_blank(o_blank), .o_bad(o_bad), .o_dp(o_dp),
    .o_seconds(o_seconds), .o_minutes(o_minutes), .o_time_ok(o_time_ok),
    .o_frame_valid(o_frame_valid), .o_stale(o_stale)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank, bad, dp;
    logic [5:0]  sec, mins;
    logic        ok, stale;
    logic [31:0] cyc;
  } frame_t;

  frame_t obs_q[$], exp_q[$];
  frame_t mon_f;
  int n_vec = 0, n_err = 0;

  always @(negedge clk) begin
    if (o_frame_valid === 1'b1) begin
      mon_f.dig   = {o_dig4, o_dig3, o_dig2, o_dig1};
      mon_f.blank = o_blank;
      mon_f.bad   = o_bad;
      mon_f.dp    = o_dp;
      mon_f.sec   = o_seconds;
      mon_f.mins  = o_minutes;
      mon_f.ok    = o_time_ok;
      mon_f.stale = o_stale;
      mon_f.cyc   = cyc;
      obs_q.push_back(mon_f);
    end
  end

  // Reference model: one slot per digit, filled by any dwell long enough to settle.
  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] m_val [4];
  logic [3:0] m_blank, m_bad, m_dp, m_mask;

  task automatic dwell(input logic [3:0] ds, input logic [7:0] s, input int len);
    int unsigned c0;
    int k, tens_s, tens_m;
    logic [3:0] v;
    logic b, bd;
    frame_t e;
    c0 = cyc;
    seg = s;
    dig_sel = ds;
    repeat (len) @(posedge clk);
    #1;
    if ($countones(~ds) == 1 && len >= SETTLE) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!ds[i]) k = i;
      v = 4'hF; b = 1'b0; bd = 1'b1;
      if (s[6:0] == 7'h7F) begin v = 4'h0; b = 1'b1; bd = 1'b0; end
      else for (int i = 0; i < 10; i++) if (glyph[i] == s[6:0]) begin v = 4'(i); bd = 1'b0; end
      m_val[k] = v; m_blank[k] = b; m_bad[k] = bd; m_dp[k] = ~s[7]; m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        e.dig   = {m_val[3], m_val[2], m_val[1], m_val[0]};
        e.blank = m_blank;
        e.bad   = m_bad;
        e.dp    = m_dp;
        e.ok    = (m_blank == 4'h0) && (m_bad == 4'h0) && (m_val[1] <= 5) && (m_val[3] <= 5);
        tens_s  = int'(m_val[1]) * 10 + int'(m_val[0]);
        tens_m  = int'(m_val[3]) * 10 + int'(m_val[2]);
        e.sec   = e.ok ? 6'(tens_s) : 6'd0;
        e.mins  = e.ok ? 6'(tens_m) : 6'd0;
        e.stale = 1'b0;
        e.cyc   = 32'(c0 + SETTLE + 2);
        exp_q.push_back(e);
        m_mask = 4'h0;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({o_dig4, o_dig3, o_dig2, o_dig1} !== 16'h0) begin
      n_err++; $display("FAIL reset_digits got %h want 0000", {o_dig4, o_dig3, o_dig2, o_dig1});
    end
    n_vec++;
    if ({o_blank, o_bad, o_dp, o_time_ok, o_frame_valid} !== 14'h0) begin
      n_err++; $display("FAIL reset_flags got %h want 0", {o_blank, o_bad, o_dp, o_time_ok, o_frame_valid});
    end
    n_vec++;
    if ({o_seconds, o_minutes} !== 12'h0) begin
      n_err++; $display("FAIL reset_time got %h want 0", {o_seconds, o_minutes});
    end
    n_vec++;
    if (o_stale !== 1'b1) begin n_err++; $display("FAIL reset_stale got %b want 1", o_stale); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_mask = 4'h0;
    n_vec++;
    if ({o_stale, o_frame_valid} !== 2'b10) begin
      n_err++; $display("FAIL post_reset got %b want 10", {o_stale, o_frame_valid});
    end
  endtask

  task automatic test_basic_frame();
    frame_t of, ef;
    dwell(4'b1110, 8'hC0, 40);
    dwell(4'b1101, 8'hF9, 40);
    dwell(4'b1011, 8'hA4, 40);
    dwell(4'b0111, 8'hB0, 40);
    dwell(4'hF, 8'hFF, 6);
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL basic_frame missing want %h", ef); end
      else begin of = obs_q.pop_front(); if (of !== ef) begin n_err++; $display("FAIL basic_frame got %h want %h", of, ef); end end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL basic_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    n_vec++;
    if ({o_dig4, o_dig3, o_dig2, o_dig1} !== 16'h3210) begin
      n_err++; $display("FAIL basic_digits got %h want 3210", {o_dig4, o_dig3, o_dig2, o_dig1});
    end
    n_vec++;
    if ({o_minutes, o_seconds, o_time_ok} !== {6'd32, 6'd10, 1'b1}) begin
      n_err++; $display("FAIL basic_time got %0d:%0d ok=%b want 32:10 ok=1", o_minutes, o_seconds, o_time_ok);
    end
  endtask

  task automatic test_short_dwell_glitch();
    frame_t of, ef;
    dwell(4'b1101, 8'hF9, 10);
    dwell(4'hF, 8'hFF, 2);
    dwell(4'b1110, 8'hC0, 5);
    dwell(4'b1110, 8'hA4, 3);
    dwell(4'b1110, 8'hB0, 16);
    dwell(4'b1011, 8'hA4, 20);
    dwell(4'b0111, 8'hF9, 20);
    dwell(4'hF, 8'hFF, 6);
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL short_dwell_captured got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    dwell(4'b1101, 8'h92, 20);
    dwell(4'hF, 8'hFF, 6);
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL glitch_frame missing want %h", ef); end
      else begin of = obs_q.pop_front(); if (of !== ef) begin n_err++; $display("FAIL glitch_frame got %h want %h", of, ef); end end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL glitch_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    n_vec++;
    if (o_dig1 !== 4'd3) begin n_err++; $display("FAIL glitch_dig1 got %h want 3", o_dig1); end
  endtask

  task automatic test_blank_bad();
    frame_t of, ef;
    dwell(4'b1110, 8'hC0, 20);
    dwell(4'b1101, 8'hFE, 20);
    dwell(4'b1011, 8'h79, 20);
    dwell(4'b0111, 8'hFF, 20);
    dwell(4'hF, 8'hFF, 6);
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL blank_bad_frame missing want %h", ef); end
      else begin of = obs_q.pop_front(); if (of !== ef) begin n_err++; $display("FAIL blank_bad_frame got %h want %h", of, ef); end end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL blank_bad_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    n_vec++;
    if ({o_blank, o_bad, o_dig2, o_dp} !== {4'b1000, 4'b0010, 4'hF, 4'b0100}) begin
      n_err++; $display("FAIL blank_bad_flags got %h want 82f4", {o_blank, o_bad, o_dig2, o_dp});
    end
    n_vec++;
    if ({o_time_ok, o_seconds, o_minutes} !== 13'h0) begin
      n_err++; $display("FAIL blank_bad_time got %h want 0", {o_time_ok, o_seconds, o_minutes});
    end
  endtask

  task automatic test_tens_six();
    frame_t of, ef;
    dwell(4'b1110, 8'h92, 20);
    dwell(4'b1101, 8'h82, 20);
    dwell(4'b1011, 8'hC0, 20);
    dwell(4'b0111, 8'hA4, 20);
    dwell(4'hF, 8'hFF, 6);
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL tens_six_frame missing want %h", ef); end
      else begin of = obs_q.pop_front(); if (of !== ef) begin n_err++; $display("FAIL tens_six_frame got %h want %h", of, ef); end end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL tens_six_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    n_vec++;
    if ({o_dig2, o_dig1, o_time_ok, o_seconds, o_minutes} !== {4'd6, 4'd5, 1'b0, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL tens_six got d2=%h d1=%h ok=%b s=%0d m=%0d want d2=6 d1=5 ok=0 s=0 m=0",
                        o_dig2, o_dig1, o_time_ok, o_seconds, o_minutes);
    end
  endtask

  task automatic test_random();
    frame_t of, ef;
    logic [3:0] ds, pds;
    logic [7:0] s, ps;
    int r, len;
    pds = 4'hF; ps = 8'hFF;
    for (int n = 0; n < 250; n++) begin
      do begin
        r = $urandom_range(0, 99);
        ds = 4'hF;
        if (r < 70) ds[$urandom_range(0, 3)] = 1'b0;
        else if (r >= 85) begin
          ds = 4'($urandom);
          while ($countones(~ds) < 2) ds = 4'($urandom);
        end
        r = $urandom_range(0, 99);
        if (r < 55)      s = {1'($urandom), glyph[$urandom_range(0, 9)]};
        else if (r < 65) s = {1'($urandom), 7'h7F};
        else             s = 8'($urandom);
      end while ({ds, s} == {pds, ps});
      len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(16, 24)) : int'($urandom_range(1, 15));
      dwell(ds, s, len);
      pds = ds; ps = s;
    end
    dwell(4'hF, 8'hFF, 6);
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL random_frame missing want %h", ef); end
      else begin of = obs_q.pop_front(); if (of !== ef) begin n_err++; $display("FAIL random_frame got %h want %h", of, ef); end end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL random_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_stale();
    frame_t of, ef;
    int unsigned pcyc;
    int guard;
    seg = 8'hFF; dig_sel = 4'hF;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_mask = 4'h0;
    n_vec++;
    if (o_stale !== 1'b1) begin n_err++; $display("FAIL stale_after_reset got %b want 1", o_stale); end
    repeat (150) @(posedge clk);
    #1;
    n_vec++;
    if (o_stale !== 1'b1) begin n_err++; $display("FAIL stale_idle got %b want 1", o_stale); end
    dwell(4'b1110, 8'hF9, 17);
    dwell(4'b1101, 8'hA4, 17);
    dwell(4'b1011, 8'hB0, 17);
    dwell(4'b0111, 8'h99, 17);
    dwell(4'hF, 8'hFF, 3);
    pcyc = cyc;
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL stale_frame missing want %h", ef); end
      else begin
        of = obs_q.pop_front(); pcyc = of.cyc;
        if (of !== ef) begin n_err++; $display("FAIL stale_frame got %h want %h", of, ef); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL stale_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    guard = 0;
    while (cyc < pcyc + TMO - 1 && guard < 500) begin @(posedge clk); #1; guard++; end
    n_vec++;
    if (guard >= 500 || o_stale !== 1'b0) begin
      n_err++; $display("FAIL stale_before_timeout got %b want 0 (guard %0d)", o_stale, guard);
    end
    @(posedge clk); #1;
    n_vec++;
    if (o_stale !== 1'b1) begin n_err++; $display("FAIL stale_at_timeout got %b want 1", o_stale); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t of, ef;
    dwell(4'b1110, 8'hC0, 20);
    dwell(4'b1101, 8'hF9, 20);
    dwell(4'b1011, 8'hA4, 20);
    seg = 8'hFF; dig_sel = 4'hF;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_dig4, o_dig3, o_dig2, o_dig1, o_seconds, o_minutes, o_time_ok} !== 29'h0) begin
      n_err++; $display("FAIL midreset_outputs got %h want 0",
                        {o_dig4, o_dig3, o_dig2, o_dig1, o_seconds, o_minutes, o_time_ok});
    end
    n_vec++;
    if (o_stale !== 1'b1) begin n_err++; $display("FAIL midreset_stale got %b want 1", o_stale); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_mask = 4'h0;
    dwell(4'b0111, 8'hB0, 40);
    dwell(4'hF, 8'hFF, 6);
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL midreset_early_frame got %0d frames want 0", obs_q.size()); obs_q.delete(); end
    dwell(4'b1110, 8'h99, 20);
    dwell(4'b1101, 8'h92, 20);
    dwell(4'b1011, 8'hF9, 20);
    dwell(4'hF, 8'hFF, 6);
    while (exp_q.size() > 0) begin
      ef = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL midreset_frame missing want %h", ef); end
      else begin of = obs_q.pop_front(); if (of !== ef) begin n_err++; $display("FAIL midreset_frame got %h want %h", of, ef); end end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL midreset_extra got %0d frames want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_mask = 4'h0; m_blank = 4'h0; m_bad = 4'h0; m_dp = 4'h0;
    for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
    test_reset();
    test_basic_frame();
    test_short_dwell_glitch();
    test_blank_bad();
    test_tens_six();
    test_random();
    test_stale();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
